// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoding flow: sequencer states,
// symbol alphabet bounds and the tree node-index convention used by the
// combine datapath and the code generator.
package huffman_pkg;

  localparam int N_SYM = 6;
  localparam logic [7:0] SYM_MIN = 8'd1;
  localparam logic [7:0] SYM_MAX = 8'd6;

  // Node indices: leaves 0..N_SYM-1 hold symbols SYM_MIN..SYM_MAX in order;
  // internal nodes are numbered N_SYM.. in creation order, so the root is last.
  localparam int NODE_W  = 4;
  localparam int N_NODES = 2 * N_SYM - 1;
  typedef logic [NODE_W-1:0] node_idx_t;
  localparam node_idx_t ROOT_NODE = node_idx_t'(N_NODES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    REPORT,
    COMBINE,
    DECODE,
    DONE,
    ERROR
  } seq_state_e;

  function automatic logic sym_in_range(input logic [7:0] sym);
    return (sym >= SYM_MIN) && (sym <= SYM_MAX);
  endfunction

  function automatic node_idx_t sym_to_leaf(input logic [7:0] sym);
    return node_idx_t'(sym - SYM_MIN);
  endfunction

endpackage

// File: rtl/huffman_seq_if.sv
// Bundle of the sequencer's stream, histogram and handshake signals.
// master: the sequencer; slave: the surrounding datapath / source.
interface huffman_seq_if #(
  parameter int CNT_W = 8
);
  logic             gray_valid;
  logic [7:0]       gray_data;
  logic [CNT_W-1:0] CNT1;
  logic [CNT_W-1:0] CNT2;
  logic [CNT_W-1:0] CNT3;
  logic [CNT_W-1:0] CNT4;
  logic [CNT_W-1:0] CNT5;
  logic [CNT_W-1:0] CNT6;
  logic             cnt_valid;
  logic             cmb_start;
  logic             cmb_done;
  logic             cmb_cmp_flg;
  logic             code_valid;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    input  gray_valid, gray_data, cmb_done, code_valid,
    output CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    output cnt_valid, cmb_start, cmb_cmp_flg, done, err, busy
  );

  modport slave (
    output gray_valid, gray_data, cmb_done, code_valid,
    input  CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    input  cnt_valid, cmb_start, cmb_cmp_flg, done, err, busy
  );
endinterface

// File: rtl/huffman_hist.sv
// Six saturating symbol counters plus the per-frame accepted-symbol counter.
// frame_full is high when the next accepted symbol completes the frame; the
// frame counter returns to zero on that symbol so every frame starts at 0.
module huffman_hist
  import huffman_pkg::*;
#(
  parameter int N_SYMBOLS = 100,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        inc,
  input  logic [7:0]                  sym,
  output logic [N_SYM-1:0][CNT_W-1:0] cnt,
  output logic                        frame_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [7:0]                  frame_cnt;
  logic [N_SYM-1:0][CNT_W-1:0] cnt_nxt;

  assign frame_full = (frame_cnt == 8'(N_SYMBOLS - 1));

  // Next bin values: optional clear first, then saturating increment of the addressed bin
  always_comb begin
    for (int i = 0; i < N_SYM; i++) begin
      cnt_nxt[i] = clr ? '0 : cnt[i];
      if (inc && sym_in_range(sym) && (sym_to_leaf(sym) == node_idx_t'(i))
          && (cnt_nxt[i] != CNT_MAX))
        cnt_nxt[i] = cnt_nxt[i] + CNT_W'(1);
    end
  end

  // Histogram bins; held except when a frame starts or a symbol is accepted
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clr || inc)
      cnt <= cnt_nxt;
  end

  // Accepted-symbol counter, wrapping to zero on the frame's last symbol
  always_ff @(posedge clk) begin
    if (reset)
      frame_cnt <= '0;
    else if (inc)
      frame_cnt <= frame_full ? 8'd0 : frame_cnt + 8'd1;
  end

endmodule

// File: rtl/huffman_seq.sv
// Huffman flow sequencer: collects a frame of symbols into the histogram,
// kicks the combine datapath, drives the code-generator handshake and
// reports completion or a handshake timeout.
module huffman_seq
  import huffman_pkg::*;
#(
  parameter int N_SYMBOLS = 100,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  huffman_seq_if.master      bus
);

  seq_state_e                  state;
  seq_state_e                  state_nxt;
  logic [7:0]                  timer;
  logic                        tmo;
  logic                        hist_clr;
  logic                        hist_inc;
  logic                        frame_full;
  logic [N_SYM-1:0][CNT_W-1:0] cnt;

  huffman_hist #(
    .N_SYMBOLS (N_SYMBOLS),
    .CNT_W     (CNT_W)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .clr        (hist_clr),
    .inc        (hist_inc),
    .sym        (bus.gray_data),
    .cnt        (cnt),
    .frame_full (frame_full)
  );

  // Wait-state cycle index; the last allowed cycle is index TIMEOUT
  assign tmo = (timer == 8'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Timeout counter: restarts on every state change, so each wait state begins at 0
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (state_nxt != state)
      timer <= '0;
    else if (timer != 8'hFF)
      timer <= timer + 8'd1;
  end

  // Next-state and histogram control; a handshake response beats an expiring timeout
  always_comb begin
    state_nxt = state;
    hist_clr  = 1'b0;
    hist_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.gray_valid) begin
          hist_clr  = 1'b1;
          hist_inc  = 1'b1;
          state_nxt = frame_full ? REPORT : COUNT;
        end
      end
      COUNT: begin
        if (bus.gray_valid) begin
          hist_inc = 1'b1;
          if (frame_full)
            state_nxt = REPORT;
        end
      end
      REPORT:  state_nxt = COMBINE;
      COMBINE: begin
        if (bus.cmb_done)
          state_nxt = DECODE;
        else if (tmo)
          state_nxt = ERROR;
      end
      DECODE: begin
        if (bus.code_valid)
          state_nxt = DONE;
        else if (tmo)
          state_nxt = ERROR;
      end
      DONE:    state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cnt_valid   = (state == REPORT);
  assign bus.cmb_start   = (state == REPORT);
  assign bus.cmb_cmp_flg = (state == DECODE) || (state == DONE);
  assign bus.done        = (state == DONE);
  assign bus.err         = (state == ERROR);
  assign bus.busy        = (state != IDLE);

  assign bus.CNT1 = cnt[0];
  assign bus.CNT2 = cnt[1];
  assign bus.CNT3 = cnt[2];
  assign bus.CNT4 = cnt[3];
  assign bus.CNT5 = cnt[4];
  assign bus.CNT6 = cnt[5];

endmodule

// File: tb/tb_huffman_seq.sv
// Directed/randomized bench for huffman_seq with a frame-level histogram model.
module tb_huffman_seq;

  localparam int N_SYMBOLS = 100;
  localparam int CNT_W     = 8;
  localparam int TIMEOUT   = 255;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_cnt [1:6];

  huffman_seq_if #(.CNT_W(CNT_W)) bus ();

  huffman_seq #(
    .N_SYMBOLS (N_SYMBOLS),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int b);
    case (b)
      1:       return 32'(bus.CNT1);
      2:       return 32'(bus.CNT2);
      3:       return 32'(bus.CNT3);
      4:       return 32'(bus.CNT4);
      5:       return 32'(bus.CNT5);
      default: return 32'(bus.CNT6);
    endcase
  endfunction

  // Histogram of a frame: legal symbols counted with saturation, others dropped
  task automatic model_frame(input int syms[$]);
    for (int b = 1; b <= 6; b++) exp_cnt[b] = 0;
    foreach (syms[i])
      if (syms[i] >= 1 && syms[i] <= 6 && exp_cnt[syms[i]] < CNT_SAT)
        exp_cnt[syms[i]]++;
  endtask

  task automatic check_counts(input string pfx);
    for (int b = 1; b <= 6; b++)
      chk($sformatf("%s_cnt%0d", pfx, b), dut_cnt(b), exp_cnt[b]);
  endtask

  task automatic shuffle(inout int q[$]);
    int j;
    int t;
    for (int i = q.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = q[i]; q[i] = q[j]; q[j] = t;
    end
  endtask

  // Feed a frame with random idle gaps; returns with the REPORT cycle checked
  task automatic send_frame(input string pfx, input int syms[$], input int max_gap);
    int gap;
    for (int i = 0; i < syms.size(); i++) begin
      gap = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        bus.gray_valid = 1'b0;
        bus.gray_data  = 8'($urandom_range(0, 255));
        tick();
      end
      bus.gray_valid = 1'b1;
      bus.gray_data  = 8'(syms[i]);
      tick();
      bus.gray_valid = 1'b0;
      if (i < syms.size() - 1) begin
        chk($sformatf("%s_cnt_valid_early%0d", pfx, i), bus.cnt_valid, 0);
        chk($sformatf("%s_busy_count", pfx), bus.busy, 1);
      end
    end
    model_frame(syms);
    chk($sformatf("%s_cnt_valid", pfx), bus.cnt_valid, 1);
    chk($sformatf("%s_cmb_start", pfx), bus.cmb_start, 1);
    chk($sformatf("%s_flg_report", pfx), bus.cmb_cmp_flg, 0);
    check_counts(pfx);
  endtask

  // From REPORT: cmb_done in COMBINE cycle cmb_delay-1, code_valid in DECODE cycle code_delay
  task automatic handshake(input string pfx, input int cmb_delay, input int code_delay,
                           input bit junk);
    tick();
    for (int i = 0; i < cmb_delay; i++) begin
      chk($sformatf("%s_flg_combine", pfx), bus.cmb_cmp_flg, 0);
      chk($sformatf("%s_start_combine", pfx), bus.cmb_start, 0);
      bus.cmb_done   = (i == cmb_delay - 1);
      bus.code_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.gray_valid = junk;
      bus.gray_data  = 8'($urandom_range(1, 6));
      tick();
    end
    bus.cmb_done = 1'b0;
    for (int j = 0; j <= code_delay; j++) begin
      chk($sformatf("%s_flg_decode", pfx), bus.cmb_cmp_flg, 1);
      chk($sformatf("%s_done_early", pfx), bus.done, 0);
      bus.code_valid = (j == code_delay);
      bus.gray_valid = junk;
      bus.gray_data  = 8'($urandom_range(1, 6));
      tick();
    end
    bus.code_valid = 1'b0;
    chk($sformatf("%s_done", pfx), bus.done, 1);
    chk($sformatf("%s_flg_done", pfx), bus.cmb_cmp_flg, 1);
    chk($sformatf("%s_err_done", pfx), bus.err, 0);
    check_counts({pfx, "_held"});
    bus.gray_valid = junk;
    tick();
    bus.gray_valid = 1'b0;
    chk($sformatf("%s_done_clear", pfx), bus.done, 0);
    chk($sformatf("%s_flg_idle", pfx), bus.cmb_cmp_flg, 0);
    chk($sformatf("%s_busy_idle", pfx), bus.busy, 0);
  endtask

  // Starting in the first wait-state cycle, count cycles until err (bounded)
  task automatic wait_err(input string pfx, input logic flg_exp);
    int n;
    bit flg_bad;
    n = 0;
    flg_bad = 1'b0;
    while (bus.err !== 1'b1 && n < 600) begin
      if (bus.cmb_cmp_flg !== flg_exp) flg_bad = 1'b1;
      bus.gray_valid = 1'($urandom_range(0, 1));
      bus.gray_data  = 8'($urandom_range(1, 6));
      tick();
      n++;
    end
    bus.gray_valid = 1'b0;
    chk($sformatf("%s_latency", pfx), n, TIMEOUT + 1);
    chk($sformatf("%s_flg_steady", pfx), flg_bad, 0);
    chk($sformatf("%s_flg_err", pfx), bus.cmb_cmp_flg, 0);
    chk($sformatf("%s_done_err", pfx), bus.done, 0);
    tick();
    chk($sformatf("%s_err_clear", pfx), bus.err, 0);
    chk($sformatf("%s_busy_idle", pfx), bus.busy, 0);
    check_counts({pfx, "_kept"});
  endtask

  task automatic rand_frame(output int q[$]);
    q = {};
    for (int i = 0; i < N_SYMBOLS; i++) q.push_back($urandom_range(1, 6));
  endtask

  initial begin
    int q[$];
    int sum;
    checks = 0;
    errors = 0;

    // Reset with every input active: reset must win
    reset          = 1'b1;
    bus.gray_valid = 1'b1;
    bus.gray_data  = 8'd3;
    bus.cmb_done   = 1'b1;
    bus.code_valid = 1'b1;
    repeat (3) tick();
    for (int b = 1; b <= 6; b++) exp_cnt[b] = 0;
    check_counts("rst");
    chk("rst_cnt_valid", bus.cnt_valid, 0);
    chk("rst_cmb_start", bus.cmb_start, 0);
    chk("rst_flg", bus.cmb_cmp_flg, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    bus.gray_valid = 1'b0;
    bus.cmb_done   = 1'b0;
    bus.code_valid = 1'b0;
    reset          = 1'b0;
    tick();

    // Nominal frame, shuffled order
    q = {};
    repeat (40) q.push_back(1);
    repeat (20) q.push_back(2);
    repeat (15) q.push_back(3);
    repeat (10) q.push_back(4);
    repeat (10) q.push_back(5);
    repeat (5)  q.push_back(6);
    shuffle(q);
    send_frame("nom", q, 0);
    chk("nom_cnt1_const", bus.CNT1, 40);
    chk("nom_cnt6_const", bus.CNT6, 5);
    handshake("nom", 3, 8, 1'b0);

    // Back-to-back frame starting in the IDLE cycle, junk input during the handshake
    rand_frame(q);
    send_frame("b2b", q, 0);
    handshake("b2b", 1 + $urandom_range(0, 5), $urandom_range(0, 6), 1'b1);

    // Gapped frame with illegal values
    q = {};
    repeat (90) q.push_back($urandom_range(1, 6));
    repeat (7)  q.push_back(0);
    repeat (3)  q.push_back(9);
    shuffle(q);
    send_frame("gap", q, 3);
    sum = 0;
    for (int b = 1; b <= 6; b++) sum += int'(dut_cnt(b));
    chk("gap_sum", sum, 90);
    handshake("gap", 2, 2, 1'b0);

    // Combine timeout
    rand_frame(q);
    send_frame("ctmo", q, 1);
    tick();
    wait_err("ctmo", 1'b0);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 50; i++) begin
      bus.gray_valid = 1'b1;
      bus.gray_data  = 8'($urandom_range(1, 6));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.gray_valid = 1'b0;
    for (int b = 1; b <= 6; b++) exp_cnt[b] = 0;
    check_counts("mrst");
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_cnt_valid", bus.cnt_valid, 0);
    rand_frame(q);
    send_frame("post", q, 2);
    // Responses land on the last permitted cycle of each wait state
    handshake("edge", TIMEOUT + 1, TIMEOUT, 1'b0);

    // Decode timeout
    rand_frame(q);
    send_frame("dtmo", q, 0);
    tick();
    bus.cmb_done = 1'b1;
    tick();
    bus.cmb_done = 1'b0;
    wait_err("dtmo", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_seq.md
# huffman_seq

Top-level sequencer for the Huffman encoding flow. Accepts the raw symbol stream, builds the six-symbol histogram, and launches the sort/combine datapath. It then drives the tree-walk code generator through its `cmb_cmp_flg` / `code_valid` handshake and reports frame completion or timeout. It sits between the input interface and the combine and code-generation datapath blocks.

## Interface
Parameters:
- `N_SYMBOLS`, 100: symbols per frame; legal range 1..255.
- `CNT_W`, 8: histogram counter width.
- `TIMEOUT`, 255: maximum wait cycles in `COMBINE` or `DECODE`; legal range 1..255.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `gray_valid`  in  1  `gray_data` is valid this cycle.
- `gray_data`  in  8  symbol value; legal values 1..6.
- `CNT1`..`CNT6`  out  `CNT_W` each  histogram counts.
- `cnt_valid`  out  1  one-cycle pulse; counts are final.
- `cmb_start`  out  1  one-cycle pulse; starts the combine datapath.
- `cmb_done`  in  1  pulse from the combine datapath; tree is ready.
- `cmb_cmp_flg`  out  1  level; requests code generation. The generator starts on its rising edge.
- `code_valid`  in  1  level from the generator; codes are complete.
- `done`  out  1  one-cycle pulse; frame complete.
- `err`  out  1  one-cycle pulse; handshake timeout.
- `busy`  out  1  high in every state except `IDLE`.

## Operation
States and transitions:
- `IDLE`: `gray_valid` moves to `COUNT`. On that same cycle all counters clear and the current symbol is counted, so it counts as symbol 1 of the new frame.
- `COUNT`: each `gray_valid` adds 1 to the frame counter.
  - For `gray_data` in 1..6, `CNT<gray_data>` increments, saturating at 2^`CNT_W`−1.
  - Values 0 or >6 are consumed but update no histogram bin.
  - When the accepted count reaches `N_SYMBOLS`, go to `REPORT`.
- `REPORT`: one cycle. `cnt_valid`=1 and `cmb_start`=1. Next state is `COMBINE`.
- `COMBINE`: wait for `cmb_done`. `cmb_done` moves to `DECODE`. After `TIMEOUT` cycles with no `cmb_done`, go to `ERROR`.
- `DECODE`: `cmb_cmp_flg`=1. `code_valid`=1 moves to `DONE`. After `TIMEOUT` cycles with no `code_valid`, go to `ERROR`.
- `DONE`: one cycle. `done`=1 and `cmb_cmp_flg` is still 1. Next state is `IDLE`, where `cmb_cmp_flg` drops to 0.
- `ERROR`: one cycle. `err`=1 and `cmb_cmp_flg`=0. Next state is `IDLE`; `CNT*` values are retained.

Rules:
- `gray_valid` is ignored in every state except `IDLE` and `COUNT`.
- `cmb_done` and `code_valid` are ignored outside their wait states.
- `CNT*` hold their values from `REPORT` until the first symbol of the next frame.
- The timeout counter clears on entry to `COMBINE` and on entry to `DECODE`.
- `N_SYMBOLS`=1 is legal: the first `gray_valid` goes from `IDLE` directly to `REPORT`.

## Timing
Reset values:
- State is `IDLE`.
- All outputs are 0, including `CNT*` and `cmb_cmp_flg`.
- Reset mid-frame takes effect on the next edge and abandons the frame.
- Reset overrides every other input in the same cycle.

Latencies:
- `cnt_valid` / `cmb_start`: the cycle after the `N_SYMBOLS`th symbol is accepted.
- `cmb_cmp_flg` rises the cycle after `cmb_done` is sampled.
- `cmb_cmp_flg` is low for at least one cycle (`IDLE`) between frames, so the generator always sees a fresh rising edge.
- `done`: the cycle after `code_valid` is sampled high.
- Timeout: `err` asserts `TIMEOUT`+1 cycles after entry to the wait state.

Minimum frame length: `N_SYMBOLS`+4 cycles when the datapath responds immediately.

Simultaneous events:
- `gray_valid` arriving in `REPORT` through `DONE` is dropped.
- `cmb_done` in the same cycle the timeout expires: `cmb_done` wins.
- `code_valid` in the same cycle the timeout expires: `code_valid` wins.

## Structure
- Shared package `huffman_pkg` holds:
  - the state enum (`IDLE`, `COUNT`, `REPORT`, `COMBINE`, `DECODE`, `DONE`, `ERROR`);
  - `N_SYM`=6;
  - the symbol range constants `SYM_MIN`=1 and `SYM_MAX`=6;
  - the node-index convention shared with the combine datapath and the code generator.
- Sub-module `huffman_hist` contains the six saturating counters and the frame counter. Its controls are `clr`, `inc`, `sym`, and a `frame_full` output.
- FSM and timeout logic stay in `huffman_seq`.

## Test plan
- **Nominal frame.** Stimulus: 100 symbols (40×1, 20×2, 15×3, 10×4, 10×5, 5×6) on consecutive cycles; `cmb_done` 3 cycles after `cmb_start`; `code_valid` 8 cycles after `cmb_cmp_flg` rises. Required response: `CNT1`..`CNT6`=40,20,15,10,10,5; `cnt_valid` the cycle after symbol 100; `done` one cycle after `code_valid`; `cmb_cmp_flg` low in the cycle after `done`.
- **Gapped and illegal input.** Stimulus: 100 `gray_valid` pulses with random idle gaps, including 7× value 0 and 3× value 9. Required response: histogram bins sum to 90; `cnt_valid` fires after the 100th pulse.
- **Combine timeout.** Stimulus: `cmb_done` never asserted. Required response: `err` pulses exactly `TIMEOUT`+1 cycles after `COMBINE` entry; `cmb_cmp_flg` never rises; `busy` drops the cycle after `err`.
- **Reset mid-frame.** Stimulus: reset after symbol 50. Required response: all outputs 0 next cycle. Then a full 100-symbol frame: counts reflect only the new frame.
- **Back-to-back frames.** Stimulus: frame 2 starts in the cycle after `done`. Required response: `cmb_cmp_flg` low for ≥1 cycle between frames; frame-2 counts are correct.
- **Ignored input.** Stimulus: symbols driven during `COMBINE` and `DECODE`. Required response: counts unchanged until the next `IDLE`.
